// File: rtl/layer_ring_tester_if.sv
// Control/status bundle between test access (master) and the layer ring tester (slave).
interface layer_ring_tester_if #(
  parameter int NUM_LAYERS = 4,
  parameter int CNT_W      = 16
);
  logic                  start;
  logic [NUM_LAYERS-1:0] layer_bypass;
  logic [NUM_LAYERS-1:0] fault_inj;
  logic                  busy;
  logic                  done;
  logic                  pass;
  logic [CNT_W-1:0]      err_count;
  logic [NUM_LAYERS-1:0] layer_finish;
  logic                  ser_out;
  logic [CNT_W-1:0]      first_err_idx;
  logic                  first_err_vld;

  modport master (
    output start, layer_bypass, fault_inj,
    input  busy, done, pass, err_count, layer_finish, ser_out, first_err_idx, first_err_vld
  );

  modport slave (
    input  start, layer_bypass, fault_inj,
    output busy, done, pass, err_count, layer_finish, ser_out, first_err_idx, first_err_vld
  );
endinterface

// File: rtl/layer_ring_tester.sv
// N-layer bypassable serial test ring with LFSR injector and delayed-reference checker.
// Optional first-error capture enabled by defining LAYER_RING_ERR_CAPTURE_EN.
module layer_ring_tester #(
  parameter int          NUM_LAYERS = 4,
  parameter int          SEG_LEN    = 8,
  parameter int          PAT_LEN    = 32,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1,
  parameter int          CNT_W      = 16
) (
  input logic                t_clk,
  input logic                rst_n,
  layer_ring_tester_if.slave bus
);
  localparam int FLUSH_LEN = NUM_LAYERS * SEG_LEN;
  localparam int CW        = $clog2(FLUSH_LEN + PAT_LEN + 1);

  typedef enum logic [2:0] {S_IDLE, S_FLUSH, S_RUN, S_DRAIN, S_DONE} state_t;

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
  endfunction

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [15:0]           inj_lfsr_q, inj_lfsr_d;
  logic [15:0]           ref_lfsr_q, ref_lfsr_d;
  logic [NUM_LAYERS-1:0] byp_q, byp_d;
  logic [NUM_LAYERS-1:0] fault_q, fault_d;
  logic [NUM_LAYERS-1:0] fin_q, fin_d;
  logic                  done_q, done_d;
  logic                  pass_q, pass_d;
  logic [CNT_W-1:0]      err_q, err_d;

  logic [SEG_LEN-1:0]    seg_q [NUM_LAYERS];
  logic [SEG_LEN-1:0]    seg_d [NUM_LAYERS];
  logic [NUM_LAYERS-1:0] seg_in, seg_raw, seg_out;

  logic [CW-1:0]         cum_len [NUM_LAYERS];
  logic [CW-1:0]         len_acc;
  logic [CW-1:0]         ring_len, last_cyc;
  logic                  active, start_acc, inj_bit, cmp_en, mismatch;

  assign active    = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign start_acc = (state_q == S_IDLE) && bus.start;
  assign inj_bit   = (state_q == S_RUN) && inj_lfsr_q[0];

  // Bypassed segments tap their first flop, so they contribute one cycle of delay.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_LAYERS; gi++) begin : g_seg
      assign seg_raw[gi] = byp_q[gi] ? seg_q[gi][0] : seg_q[gi][SEG_LEN-1];
      assign seg_out[gi] = seg_raw[gi] ^ (fault_q[gi] & active);
      if (gi == 0) begin : g_head
        assign seg_in[gi] = inj_bit;
      end else begin : g_link
        assign seg_in[gi] = seg_out[gi-1];
      end
      assign seg_d[gi] = {seg_q[gi][SEG_LEN-2:0], seg_in[gi]};
    end
  endgenerate

  always_comb begin
    len_acc = '0;
    for (int i = 0; i < NUM_LAYERS; i++) begin
      len_acc    = len_acc + (byp_q[i] ? CW'(1) : CW'(SEG_LEN));
      cum_len[i] = len_acc;
    end
  end

  assign ring_len = cum_len[NUM_LAYERS-1];
  assign last_cyc = ring_len + CW'(PAT_LEN - 1);
  assign cmp_en   = active && (cnt_q >= ring_len) && (cnt_q <= last_cyc);
  assign mismatch = cmp_en && (seg_out[NUM_LAYERS-1] != ref_lfsr_q[0]);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    inj_lfsr_d = inj_lfsr_q;
    ref_lfsr_d = ref_lfsr_q;
    byp_d      = byp_q;
    fault_d    = fault_q;
    fin_d      = fin_q;
    done_d     = done_q;
    pass_d     = pass_q;
    err_d      = err_q;

    if (cmp_en) begin
      ref_lfsr_d = lfsr_step(ref_lfsr_q);
      if (mismatch && (err_q != {CNT_W{1'b1}})) begin
        err_d = err_q + CNT_W'(1);
      end
    end
    if (active) begin
      for (int i = 0; i < NUM_LAYERS; i++) begin
        if (cnt_q == cum_len[i] + CW'(PAT_LEN - 1)) begin
          fin_d[i] = 1'b1;
        end
      end
    end

    case (state_q)
      S_IDLE: begin
        if (start_acc) begin
          state_d    = S_FLUSH;
          cnt_d      = '0;
          byp_d      = bus.layer_bypass;
          fault_d    = bus.fault_inj;
          fin_d      = '0;
          done_d     = 1'b0;
          pass_d     = 1'b0;
          err_d      = '0;
          inj_lfsr_d = LFSR_SEED;
          ref_lfsr_d = LFSR_SEED;
        end
      end
      S_FLUSH: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(FLUSH_LEN - 1)) begin
          state_d = S_RUN;
          cnt_d   = '0;
        end
      end
      S_RUN: begin
        inj_lfsr_d = lfsr_step(inj_lfsr_q);
        cnt_d      = cnt_q + CW'(1);
        if (cnt_q == CW'(PAT_LEN - 1)) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == last_cyc) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          pass_d  = (err_d == '0);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge t_clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      inj_lfsr_q <= '0;
      ref_lfsr_q <= '0;
      byp_q      <= '0;
      fault_q    <= '0;
      fin_q      <= '0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      err_q      <= '0;
      for (int i = 0; i < NUM_LAYERS; i++) begin
        seg_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      inj_lfsr_q <= inj_lfsr_d;
      ref_lfsr_q <= ref_lfsr_d;
      byp_q      <= byp_d;
      fault_q    <= fault_d;
      fin_q      <= fin_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
      err_q      <= err_d;
      for (int i = 0; i < NUM_LAYERS; i++) begin
        seg_q[i] <= seg_d[i];
      end
    end
  end

  assign bus.busy         = (state_q == S_FLUSH) || active;
  assign bus.done         = done_q;
  assign bus.pass         = pass_q;
  assign bus.err_count    = err_q;
  assign bus.layer_finish = fin_q;
  assign bus.ser_out      = seg_out[NUM_LAYERS-1];

`ifdef LAYER_RING_ERR_CAPTURE_EN
  logic             fe_vld_q, fe_vld_d;
  logic [CNT_W-1:0] fe_idx_q, fe_idx_d;

  // Only the first mismatch of a run is recorded; later ones leave it alone.
  always_comb begin
    fe_vld_d = fe_vld_q;
    fe_idx_d = fe_idx_q;
    if (start_acc) begin
      fe_vld_d = 1'b0;
      fe_idx_d = '0;
    end else if (mismatch && !fe_vld_q) begin
      fe_vld_d = 1'b1;
      fe_idx_d = CNT_W'(cnt_q - ring_len);
    end
  end

  always_ff @(posedge t_clk) begin
    if (!rst_n) begin
      fe_vld_q <= 1'b0;
      fe_idx_q <= '0;
    end else begin
      fe_vld_q <= fe_vld_d;
      fe_idx_q <= fe_idx_d;
    end
  end

  assign bus.first_err_idx = fe_idx_q;
  assign bus.first_err_vld = fe_vld_q;
`else
  assign bus.first_err_idx = '0;
  assign bus.first_err_vld = 1'b0;
`endif
endmodule

// File: tb/tb_layer_ring_tester.sv
// Self-checking bench for layer_ring_tester: directed and randomized runs against a stream-level model.
module tb_layer_ring_tester;
  localparam int          NL    = 4;
  localparam int          SEG   = 8;
  localparam int          PAT   = 32;
  localparam int          CW    = 16;
  localparam int          FL    = NL * SEG;
  localparam int          PAT_S = 40;
  localparam int          CW_S  = 4;
  localparam logic [15:0] SEED  = 16'hACE1;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int vectors     = 0;
  int miscompares = 0;

  layer_ring_tester_if #(.NUM_LAYERS(NL), .CNT_W(CW))   bus ();
  layer_ring_tester_if #(.NUM_LAYERS(NL), .CNT_W(CW_S)) bus_s ();

  layer_ring_tester #(.NUM_LAYERS(NL), .SEG_LEN(SEG), .PAT_LEN(PAT),
                      .LFSR_SEED(SEED), .CNT_W(CW)) dut (
    .t_clk(clk), .rst_n(rst_n), .bus(bus));

  layer_ring_tester #(.NUM_LAYERS(NL), .SEG_LEN(SEG), .PAT_LEN(PAT_S),
                      .LFSR_SEED(SEED), .CNT_W(CW_S)) dut_s (
    .t_clk(clk), .rst_n(rst_n), .bus(bus_s));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // k-th bit of the injected pattern: low bit of the seed after k LFSR steps.
  function automatic bit pat_bit(input int k);
    logic [15:0] s;
    s = SEED;
    for (int j = 0; j < k; j++) s = {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
    return s[0];
  endfunction

  task automatic check_idle_zero(input string tag);
    check({tag, "_busy"},  bus.busy, 0);
    check({tag, "_done"},  bus.done, 0);
    check({tag, "_pass"},  bus.pass, 0);
    check({tag, "_err"},   bus.err_count, 0);
    check({tag, "_fin"},   bus.layer_finish, 0);
    check({tag, "_ser"},   bus.ser_out, 0);
    check({tag, "_fidx"},  bus.first_err_idx, 0);
    check({tag, "_fvld"},  bus.first_err_vld, 0);
  endtask

  task automatic run_main(input logic [NL-1:0] byp, input logic [NL-1:0] flt,
                          input bit noise, input string name);
    int L;
    int D[NL];
    int t_end;
    int errs;
    int first;
    bit par;
    logic [NL-1:0] fin_exp;
    L = 0;
    for (int i = 0; i < NL; i++) begin
      L += byp[i] ? 1 : SEG;
      D[i] = L;
    end
    par   = ^flt;
    errs  = 0;
    first = -1;
    for (int k = 0; k < PAT; k++) begin
      if ((pat_bit(k) ^ par) != pat_bit(k)) begin
        errs++;
        if (first < 0) first = k;
      end
    end
    t_end = FL + PAT + L;

    @(negedge clk);
    bus.start = 1'b1; bus.layer_bypass = byp; bus.fault_inj = flt;
    @(negedge clk);
    bus.start = 1'b0;
    check({name, "_done_clr"}, bus.done, 0);
    check({name, "_err_clr"},  bus.err_count, 0);
    for (int t = 0; t < t_end; t++) begin
      check({name, "_busy"}, bus.busy, 1);
      for (int i = 0; i < NL; i++) fin_exp[i] = (t >= FL + D[i] + PAT);
      check({name, "_fin"}, bus.layer_finish, fin_exp);
      if (t >= FL + L && t < FL + L + PAT)
        check({name, "_ser"}, bus.ser_out, pat_bit(t - FL - L) ^ par);
      if (noise) begin
        bus.start        = 1'($urandom_range(0, 1));
        bus.layer_bypass = NL'($urandom);
        bus.fault_inj    = NL'($urandom);
      end
      @(negedge clk);
    end
    bus.start = 1'b0;
    check({name, "_end_busy"}, bus.busy, 0);
    check({name, "_end_done"}, bus.done, 1);
    check({name, "_end_err"},  bus.err_count, errs);
    check({name, "_end_pass"}, bus.pass, errs == 0);
    check({name, "_end_fin"},  bus.layer_finish, {NL{1'b1}});
`ifdef LAYER_RING_ERR_CAPTURE_EN
    check({name, "_end_fvld"}, bus.first_err_vld, errs > 0);
    check({name, "_end_fidx"}, bus.first_err_idx, (first < 0) ? 0 : first);
`else
    check({name, "_end_fvld"}, bus.first_err_vld, 0);
    check({name, "_end_fidx"}, bus.first_err_idx, 0);
`endif
    @(negedge clk);
    check({name, "_hold_done"}, bus.done, 1);
    check({name, "_hold_busy"}, bus.busy, 0);
    check({name, "_hold_pass"}, bus.pass, errs == 0);
    $display("run %s: bypass=%b fault=%b L=%0d err_count=%0d pass=%0d",
             name, byp, flt, L, bus.err_count, bus.pass);
  endtask

  initial begin
    int errs_s;
    int exp_s;
    int t_done;
    bus.start = 1'b0;   bus.layer_bypass = '0;   bus.fault_inj = '0;
    bus_s.start = 1'b0; bus_s.layer_bypass = '0; bus_s.fault_inj = '0;
    repeat (3) @(negedge clk);
    check_idle_zero("reset");
    check("reset_s_err",  bus_s.err_count, 0);
    check("reset_s_done", bus_s.done, 0);
    rst_n = 1'b1;
    @(negedge clk);

    run_main(4'b0000, 4'b0000, 1'b0, "base");
    run_main(4'b0101, 4'b0000, 1'b0, "bypass");
    run_main(4'b0000, 4'b0010, 1'b0, "fault_odd");
    run_main(4'b0000, 4'b0011, 1'b0, "fault_even");

    // Abort mid-RUN with a one-cycle reset.
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (FL + 10) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check_idle_zero("midrst");
    repeat (2) @(negedge clk);
    check("midrst_nodone", bus.done, 0);
    run_main(4'b0000, 4'b0000, 1'b1, "after_rst");

    for (int r = 0; r < 4; r++)
      run_main(NL'($urandom), NL'($urandom), 1'b1, $sformatf("rand%0d", r));

    // Error counter saturation on the long-pattern, narrow-counter instance.
    errs_s = 0;
    for (int k = 0; k < PAT_S; k++) if ((pat_bit(k) ^ 1'b1) != pat_bit(k)) errs_s++;
    exp_s = (errs_s > (1 << CW_S) - 1) ? (1 << CW_S) - 1 : errs_s;
    @(negedge clk);
    bus_s.start = 1'b1; bus_s.fault_inj = 4'b0001;
    @(negedge clk);
    bus_s.start = 1'b0;
    t_done = -1;
    for (int t = 0; t < 400 && t_done < 0; t++) begin
      if (bus_s.done) t_done = t;
      else @(negedge clk);
    end
    check("sat_done_cycle", t_done, FL + PAT_S + FL);
    check("sat_err",  bus_s.err_count, exp_s);
    check("sat_pass", bus_s.pass, 0);
    $display("run sat: fault=0001 err_count=%0d pass=%0d done_cycle=%0d",
             bus_s.err_count, bus_s.pass, t_done);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
